// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 datapath bus gate scheduler:
// bus source indices, the source id type, the scheduler state encoding
// and a one-hot helper.
package lc3_bus_pkg;

   typedef logic [1:0] src_id_t;

   localparam src_id_t SRC_MARMUX = 2'd0;
   localparam src_id_t SRC_PC     = 2'd1;
   localparam src_id_t SRC_ALU    = 2'd2;
   localparam src_id_t SRC_MDR    = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DEAD  = 2'd2
   } state_t;

   // Gate enable vector with only the given source's bit set.
   function automatic logic [3:0] src_onehot(input src_id_t id);
      src_onehot = 4'b0001 << id;
   endfunction

endpackage

// File: rtl/bus_gate_arbiter_rr_pick4.sv
// Four-way round-robin picker. Searches elig starting at the entry just
// after ptr and wrapping, so ptr itself is examined last. Purely
// combinational; idx is only meaningful when found is high.
module rr_pick4
   import lc3_bus_pkg::*;
(
   input  logic [3:0] elig,
   input  src_id_t    ptr,
   output logic       found,
   output src_id_t    idx
);

   src_id_t cand;

   // First eligible entry at ptr+1, ptr+2, ptr+3, ptr (mod 4).
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + 2'(k);
         if (!found && elig[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Registered round-robin scheduler for the four tri-state gate enables
// driving the shared 16-bit datapath bus. At most one enable is high in
// any cycle, owners are separated by DEAD_CYCLES all-low cycles, and an
// owner still requesting after MAX_HOLD cycles is cut off, reported on
// timeout_pulse/timeout_id, and masked until it drops its request.
//
// Handshake: req[i] is a level request held high while source i needs the
// bus; the matching enable is the grant. A source releases the bus by
// dropping req; its enable falls in the following cycle. A request that
// drops before it is granted is forgotten (no queueing).
module bus_gate_arbiter
   import lc3_bus_pkg::*;
#(
   parameter int unsigned MAX_HOLD    = 8,
   parameter int unsigned DEAD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic       enaMARM,
   output logic       enaPC,
   output logic       enaALU,
   output logic       enaMDR,
   output logic       gnt_valid,
   output logic [1:0] gnt_id,
   output logic       timeout_pulse,
   output logic [1:0] timeout_id
);

   localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [1:0] DEAD_LAST =
      (DEAD_CYCLES == 0) ? 2'd0 : 2'(DEAD_CYCLES - 1);

   state_t            state_q, state_d;
   src_id_t           rr_ptr_q, rr_ptr_d;
   src_id_t           owner_q, owner_d;
   logic [3:0]        mask_q, mask_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]        dead_cnt_q, dead_cnt_d;

   logic [3:0]        en_q, en_d;
   logic              gnt_valid_q, gnt_valid_d;
   src_id_t           gnt_id_q, gnt_id_d;
   logic              timeout_pulse_q, timeout_pulse_d;
   src_id_t           timeout_id_q, timeout_id_d;

   logic              owner_req;
   logic              release_now;
   logic              timeout_now;
   logic [3:0]        elig;
   logic              pick_found;
   src_id_t           pick_idx;

   // Release/timeout decisions and the mask for the next cycle. Eligibility
   // uses the updated mask so a just-revoked owner cannot win the
   // arbitration that happens at its own release edge.
   always_comb begin
      owner_req   = req[owner_q];
      release_now = (state_q == GRANT) && !owner_req;
      timeout_now = TIMEOUT_EN && (state_q == GRANT) && owner_req &&
                    (hold_cnt_q == HOLD_LAST);
      mask_d = mask_q & req;
      if (timeout_now) begin
         mask_d[owner_q] = 1'b1;
      end
      elig = req & ~mask_d;
   end

   rr_pick4 u_pick (
      .elig  (elig),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Scheduler state, pointer, owner, mask and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= SRC_MDR;
         owner_q    <= SRC_MARMUX;
         mask_q     <= 4'b0000;
         hold_cnt_q <= '0;
         dead_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         mask_q     <= mask_d;
         hold_cnt_q <= hold_cnt_d;
         dead_cnt_q <= dead_cnt_d;
      end
   end

   // Next-state logic: arbitrate from IDLE, at the end of the dead gap, or
   // directly at a release edge when no dead gap is configured.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      dead_cnt_d = dead_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = GRANT;
               rr_ptr_d   = pick_idx;
               owner_d    = pick_idx;
               hold_cnt_d = '0;
            end
         end
         GRANT: begin
            if (release_now || timeout_now) begin
               if (DEAD_CYCLES == 0) begin
                  if (pick_found) begin
                     state_d    = GRANT;
                     rr_ptr_d   = pick_idx;
                     owner_d    = pick_idx;
                     hold_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d    = DEAD;
                  dead_cnt_d = 2'd0;
               end
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         DEAD: begin
            if (dead_cnt_q == DEAD_LAST) begin
               if (pick_found) begin
                  state_d    = GRANT;
                  rr_ptr_d   = pick_idx;
                  owner_d    = pick_idx;
                  hold_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               dead_cnt_d = dead_cnt_q + 2'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next output values; every output is a flop so req never reaches an
   // enable combinationally, and the enable vector is built from a single
   // owner index so it is always one-hot or zero.
   always_comb begin
      en_d        = 4'b0000;
      gnt_valid_d = 1'b0;
      gnt_id_d    = SRC_MARMUX;
      if (state_d == GRANT) begin
         en_d        = src_onehot(owner_d);
         gnt_valid_d = 1'b1;
         gnt_id_d    = owner_d;
      end
      timeout_pulse_d = timeout_now;
      timeout_id_d    = timeout_now ? owner_q : SRC_MARMUX;
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q            <= 4'b0000;
         gnt_valid_q     <= 1'b0;
         gnt_id_q        <= SRC_MARMUX;
         timeout_pulse_q <= 1'b0;
         timeout_id_q    <= SRC_MARMUX;
      end else begin
         en_q            <= en_d;
         gnt_valid_q     <= gnt_valid_d;
         gnt_id_q        <= gnt_id_d;
         timeout_pulse_q <= timeout_pulse_d;
         timeout_id_q    <= timeout_id_d;
      end
   end

   assign enaMARM       = en_q[SRC_MARMUX];
   assign enaPC         = en_q[SRC_PC];
   assign enaALU        = en_q[SRC_ALU];
   assign enaMDR        = en_q[SRC_MDR];
   assign gnt_valid     = gnt_valid_q;
   assign gnt_id        = gnt_id_q;
   assign timeout_pulse = timeout_pulse_q;
   assign timeout_id    = timeout_id_q;

endmodule
